fold_accumulator: RTL and testbench

Parametrised multi-channel pulse-folding profile accumulator; successor to the single-channel phase-bin/profile path. Counts rising edges on `NUM_CH` pulse inputs into `2^BIN_BITS` phase bins over a programmable number of periods, after a programmable epoch delay. It then streams the folded profiles out with valid/ready backpressure and reports a per-channel peak bin. It sits between the pulse input stage and downstream profile storage/analysis.

---
 rtl/fold_pkg.sv | 26 ++
 rtl/fold_accumulator_if.sv | 43 ++++
 rtl/fold_phase_gen.sv | 96 +++++++++
 rtl/fold_accumulator.sv | 207 ++++++++++++++++++++
 tb/tb_fold_accumulator.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fold_pkg.sv
// Shared types and helpers for the multi-channel pulse-folding profile accumulator.
package fold_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_EPOCH = 2'd1,
        ST_FOLD       = 2'd2,
        ST_READOUT    = 2'd3
    } fold_state_e;

    // Number of phase bins for a given log2 bin count.
    function automatic int nbins(input int bin_bits);
        return 32'sd1 << bin_bits;
    endfunction

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 32'sd1) ? 32'sd1 : $clog2(num_ch);
    endfunction

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fold_accumulator_if.sv
// Control, pulse, readout and peak-report bundle of the fold accumulator.
interface fold_accumulator_if
    import fold_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int BIN_BITS = 3,
    parameter int CNT_W    = 16,
    parameter int TIME_W   = 32
);
    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0]   pulse_in;
    logic                start;
    logic [TIME_W-1:0]   period;
    logic [TIME_W-1:0]   epoch;
    logic [TIME_W-1:0]   fold_len;
    logic                busy;
    logic                err;
    logic [BIN_BITS-1:0] cur_bin;
    logic                out_valid;
    logic                out_ready;
    logic [CH_W-1:0]     out_ch;
    logic [BIN_BITS-1:0] out_bin;
    logic [CNT_W-1:0]    out_count;
    logic                out_last;
    logic                peak_valid;
    logic [CH_W-1:0]     peak_ch;
    logic [BIN_BITS-1:0] peak_bin;
    logic [CNT_W-1:0]    peak_count;

    modport master (
        output pulse_in, start, period, epoch, fold_len, out_ready,
        input  busy, err, cur_bin, out_valid, out_ch, out_bin, out_count, out_last,
               peak_valid, peak_ch, peak_bin, peak_count
    );

    modport slave (
        input  pulse_in, start, period, epoch, fold_len, out_ready,
        output busy, err, cur_bin, out_valid, out_ch, out_bin, out_count, out_last,
               peak_valid, peak_ch, peak_bin, peak_count
    );

endinterface

// File: rtl/fold_phase_gen.sv
// Epoch delay, divider-free phase-to-bin mapping and period counting for one fold.
module fold_phase_gen
    import fold_pkg::*;
#(
    parameter int BIN_BITS = 3,
    parameter int TIME_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                in_wait,
    input  logic                in_fold,
    input  logic [TIME_W-1:0]   period,
    input  logic [TIME_W-1:0]   epoch,
    input  logic [TIME_W-1:0]   fold_len,
    output logic                epoch_done,
    output logic [BIN_BITS-1:0] cur_bin,
    output logic                period_wrap,
    output logic                fold_done
);
    localparam int              NBINS   = nbins(BIN_BITS);
    localparam logic [TIME_W:0] NBINS_W = (TIME_W + 1)'(NBINS);
    localparam logic [TIME_W:0] ONE_W   = (TIME_W + 1)'(1'b1);
    localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(1'b1);
    localparam logic [TIME_W-1:0] ZERO_T = {TIME_W{1'b0}};

    logic [TIME_W-1:0]   period_r;
    logic [TIME_W-1:0]   epoch_r;
    logic [TIME_W-1:0]   fold_len_r;
    logic [TIME_W-1:0]   ecnt_r;
    logic [TIME_W-1:0]   phase_r;
    logic [TIME_W-1:0]   acc_r;
    logic [TIME_W-1:0]   pcnt_r;
    logic [BIN_BITS-1:0] bin_r;
    logic [TIME_W:0]     sum_s;
    logic [TIME_W-1:0]   acc_add_s;
    logic [TIME_W-1:0]   acc_sub_s;
    logic                step_bin_s;

    // Bresenham step (acc keeps p*NBINS mod period) and end-of-epoch/period/fold detection.
    always_comb begin
        sum_s       = {1'b0, acc_r} + NBINS_W;
        acc_add_s   = sum_s[TIME_W-1:0];
        acc_sub_s   = acc_add_s - period_r;
        step_bin_s  = (sum_s >= {1'b0, period_r});
        epoch_done  = in_wait && (({1'b0, ecnt_r} + ONE_W) >= {1'b0, epoch_r});
        period_wrap = in_fold && (phase_r == (period_r - ONE_T));
        fold_done   = in_fold && (({1'b0, pcnt_r} + ONE_W) >= {1'b0, fold_len_r});
    end

    assign cur_bin = bin_r;

    // Latch the fold configuration on an accepted start and step the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r   <= ZERO_T;
            epoch_r    <= ZERO_T;
            fold_len_r <= ZERO_T;
            ecnt_r     <= ZERO_T;
            phase_r    <= ZERO_T;
            acc_r      <= ZERO_T;
            pcnt_r     <= ZERO_T;
            bin_r      <= {BIN_BITS{1'b0}};
        end else if (load) begin
            period_r   <= period;
            epoch_r    <= epoch;
            fold_len_r <= (fold_len == ZERO_T) ? ONE_T : fold_len;
            ecnt_r     <= ZERO_T;
            phase_r    <= ZERO_T;
            acc_r      <= ZERO_T;
            pcnt_r     <= ZERO_T;
            bin_r      <= {BIN_BITS{1'b0}};
        end else begin
            if (in_wait) begin
                ecnt_r <= ecnt_r + ONE_T;
            end
            if (in_fold) begin
                if (period_wrap) begin
                    phase_r <= ZERO_T;
                    acc_r   <= ZERO_T;
                    bin_r   <= {BIN_BITS{1'b0}};
                    pcnt_r  <= pcnt_r + ONE_T;
                end else begin
                    phase_r <= phase_r + ONE_T;
                    if (step_bin_s) begin
                        acc_r <= acc_sub_s;
                        bin_r <= bin_r + BIN_BITS'(1'b1);
                    end else begin
                        acc_r <= acc_add_s;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fold_accumulator.sv
// Multi-channel pulse-folding profile accumulator: counts rising edges per phase bin,
// then streams the profiles out with valid/ready and reports a per-channel peak.
module fold_accumulator
    import fold_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int BIN_BITS = 3,
    parameter int CNT_W    = 16,
    parameter int TIME_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fold_accumulator_if.slave bus
);
    localparam int                  NBINS    = nbins(BIN_BITS);
    localparam int                  CH_W     = ch_idx_w(NUM_CH);
    localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NBINS - 1);

    fold_state_e         state_r;
    logic [NUM_CH-1:0]   pulse_prev_r;
    logic [NUM_CH-1:0]   edge_s;
    logic [CNT_W-1:0]    counts_r     [NUM_CH][NBINS];
    logic [CNT_W-1:0]    counts_nxt_s [NUM_CH][NBINS];
    logic [BIN_BITS-1:0] cur_bin_s;
    logic                load_s;
    logic                epoch_done_s;
    logic                period_wrap_s;
    logic                fold_done_s;
    logic                hs_s;
    logic [CH_W-1:0]     nxt_ch_s;
    logic [BIN_BITS-1:0] nxt_bin_s;
    logic                nxt_last_s;
    logic [BIN_BITS-1:0] pk_bin_r;
    logic [CNT_W-1:0]    pk_cnt_r;
    logic [BIN_BITS-1:0] pk_bin_new_s;
    logic [CNT_W-1:0]    pk_cnt_new_s;

    assign edge_s      = bus.pulse_in & ~pulse_prev_r;
    assign hs_s        = bus.out_valid & bus.out_ready;
    assign load_s      = (state_r == ST_IDLE) && bus.start && (bus.period >= TIME_W'(NBINS));
    assign bus.cur_bin = cur_bin_s;

    fold_phase_gen #(
        .BIN_BITS (BIN_BITS),
        .TIME_W   (TIME_W)
    ) u_phase_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .in_wait     (state_r == ST_WAIT_EPOCH),
        .in_fold     (state_r == ST_FOLD),
        .period      (bus.period),
        .epoch       (bus.epoch),
        .fold_len    (bus.fold_len),
        .epoch_done  (epoch_done_s),
        .cur_bin     (cur_bin_s),
        .period_wrap (period_wrap_s),
        .fold_done   (fold_done_s)
    );

    // Edge-detect history tracks the pulse inputs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_prev_r <= {NUM_CH{1'b0}};
        end else begin
            pulse_prev_r <= bus.pulse_in;
        end
    end

    // Next count file: saturating increment on an edge during FOLD, clear on an accepted beat.
    always_comb begin
        counts_nxt_s = counts_r;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < NBINS; b++) begin
                if ((state_r == ST_FOLD) && edge_s[c] && (cur_bin_s == BIN_BITS'(b))) begin
                    counts_nxt_s[c][b] = CNT_W'(sat_inc(32'(counts_r[c][b]), 32'(CNT_MAX)));
                end else if (hs_s && (bus.out_ch == CH_W'(c)) && (bus.out_bin == BIN_BITS'(b))) begin
                    counts_nxt_s[c][b] = {CNT_W{1'b0}};
                end else begin
                    counts_nxt_s[c][b] = counts_r[c][b];
                end
            end
        end
    end

    // Count register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NBINS; b++) begin
                    counts_r[c][b] <= {CNT_W{1'b0}};
                end
            end
        end else begin
            counts_r <= counts_nxt_s;
        end
    end

    // Next readout beat index and running peak candidate (strict greater-than keeps lowest bin).
    always_comb begin
        nxt_ch_s     = bus.out_ch;
        nxt_bin_s    = bus.out_bin + BIN_BITS'(1'b1);
        pk_bin_new_s = pk_bin_r;
        pk_cnt_new_s = pk_cnt_r;
        if (bus.out_bin == LAST_BIN) begin
            nxt_ch_s  = bus.out_ch + CH_W'(1'b1);
            nxt_bin_s = {BIN_BITS{1'b0}};
        end else begin
            nxt_ch_s  = bus.out_ch;
            nxt_bin_s = bus.out_bin + BIN_BITS'(1'b1);
        end
        nxt_last_s = (nxt_ch_s == LAST_CH) && (nxt_bin_s == LAST_BIN);
        if ((bus.out_bin == {BIN_BITS{1'b0}}) || (bus.out_count > pk_cnt_r)) begin
            pk_bin_new_s = bus.out_bin;
            pk_cnt_new_s = bus.out_count;
        end else begin
            pk_bin_new_s = pk_bin_r;
            pk_cnt_new_s = pk_cnt_r;
        end
    end

    // Control FSM with registered status, readout and peak outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= {CH_W{1'b0}};
            bus.out_bin    <= {BIN_BITS{1'b0}};
            bus.out_count  <= {CNT_W{1'b0}};
            bus.out_last   <= 1'b0;
            bus.peak_valid <= 1'b0;
            bus.peak_ch    <= {CH_W{1'b0}};
            bus.peak_bin   <= {BIN_BITS{1'b0}};
            bus.peak_count <= {CNT_W{1'b0}};
            pk_bin_r       <= {BIN_BITS{1'b0}};
            pk_cnt_r       <= {CNT_W{1'b0}};
        end else begin
            bus.peak_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r  <= ST_WAIT_EPOCH;
                        bus.busy <= 1'b1;
                        bus.err  <= 1'b0;
                    end else if (bus.start) begin
                        bus.err <= 1'b1;
                    end
                end
                ST_WAIT_EPOCH: begin
                    if (epoch_done_s) begin
                        state_r <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    // fold_done flags the final period; its wrap closes the fold.
                    if (period_wrap_s && fold_done_s) begin
                        state_r       <= ST_READOUT;
                        bus.out_valid <= 1'b1;
                        bus.out_ch    <= {CH_W{1'b0}};
                        bus.out_bin   <= {BIN_BITS{1'b0}};
                        bus.out_count <= counts_nxt_s[0][0];
                        bus.out_last  <= 1'b0;
                        pk_bin_r      <= {BIN_BITS{1'b0}};
                        pk_cnt_r      <= {CNT_W{1'b0}};
                    end
                end
                ST_READOUT: begin
                    if (hs_s) begin
                        pk_bin_r <= pk_bin_new_s;
                        pk_cnt_r <= pk_cnt_new_s;
                        if (bus.out_bin == LAST_BIN) begin
                            bus.peak_valid <= 1'b1;
                            bus.peak_ch    <= bus.out_ch;
                            bus.peak_bin   <= pk_bin_new_s;
                            bus.peak_count <= pk_cnt_new_s;
                        end
                        if (bus.out_last) begin
                            state_r       <= ST_IDLE;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_ch    <= {CH_W{1'b0}};
                            bus.out_bin   <= {BIN_BITS{1'b0}};
                            bus.out_count <= {CNT_W{1'b0}};
                        end else begin
                            bus.out_ch    <= nxt_ch_s;
                            bus.out_bin   <= nxt_bin_s;
                            bus.out_count <= counts_nxt_s[nxt_ch_s][nxt_bin_s];
                            bus.out_last  <= nxt_last_s;
                        end
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bus.busy      <= 1'b0;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fold_accumulator.sv
// Self-checking bench for fold_accumulator: randomized and directed folds checked
// against a phase/bin arithmetic reference model of the folding rules.
module tb_fold_accumulator;
    localparam int NUM_CH   = 2;
    localparam int BIN_BITS = 3;
    localparam int CNT_W    = 4;
    localparam int TIME_W   = 32;
    localparam int NBINS    = 8;
    localparam int NBEATS   = NUM_CH * NBINS;
    localparam int CMAX     = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fold_accumulator_if #(.NUM_CH(NUM_CH), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W), .TIME_W(TIME_W)) bus ();

    fold_accumulator #(.NUM_CH(NUM_CH), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mdl [NUM_CH][NBINS];
    logic [NUM_CH-1:0] prev_lvl = '0;

    task automatic tick();
        prev_lvl = bus.pulse_in;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++)
            for (int b = 0; b < NBINS; b++)
                mdl[c][b] = 0;
    endtask

    // Pulse levels for a given scenario and phase (p < 0 means outside FOLD).
    function automatic logic [1:0] pattern(input int mode, input int p);
        logic [1:0] v;
        v = 2'b00;
        case (mode)
            0: if (p >= 0) v = {(p == 15), (p == 0 || p == 5)};
            1: if (p >= 24 && p <= 30 && (p % 2) == 0) v = 2'b01;
            2: if (p == 1) v = 2'b11;
            3: v = 2'($urandom);
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // Start a fold and drive it through WAIT_EPOCH and FOLD, updating the model.
    task automatic run_fold(input int per, input int ep, input int fl, input int mode,
                            input bit poke_start, input int abort_at);
        int fl_eff = (fl == 0) ? 1 : fl;
        int wcyc = (ep == 0) ? 1 : ep;
        int fcyc = per * fl_eff;
        bus.period = per; bus.epoch = ep; bus.fold_len = fl; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL start_busy got %b want 1", bus.busy); end
        n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL start_err_clear got %b want 0", bus.err); end
        for (int t = 0; t < wcyc + fcyc; t++) begin
            int f = t - wcyc;
            int p = (f >= 0) ? (f % per) : -1;
            logic [1:0] lvl;
            if (abort_at >= 0 && f == abort_at) begin
                rst_n = 1'b0; bus.pulse_in = '0;
                #1;
                n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
                n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid got %b want 0", bus.out_valid); end
                tick(); tick();
                rst_n = 1'b1;
                tick();
                clear_model();
                return;
            end
            lvl = pattern(mode, p);
            if (poke_start && t == 0) begin bus.start = 1'b1; bus.period = 2; end
            bus.pulse_in = lvl;
            if (f >= 0) begin
                n_checks++;
                if (int'(bus.cur_bin) !== (p * NBINS) / per) begin
                    n_errors++; $display("FAIL cur_bin p=%0d got %0d want %0d", p, bus.cur_bin, (p * NBINS) / per);
                end
                for (int c = 0; c < NUM_CH; c++)
                    if (lvl[c] && !prev_lvl[c] && mdl[c][(p * NBINS) / per] < CMAX)
                        mdl[c][(p * NBINS) / per]++;
            end
            tick();
            bus.start = 1'b0;
        end
        if (poke_start) begin
            n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL ignored_start_err got %b want 0", bus.err); end
        end
    endtask

    // Drain all beats, checking each against the model and the per-channel peak reports.
    task automatic do_readout(input bit rnd_ready, input bit rnd_pulse);
        int exp_pb [NUM_CH];
        int exp_pc [NUM_CH];
        int beat = 0;
        int cyc = 0;
        bit pk_pend = 0;
        int pk_ch = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_pb[c] = 0; exp_pc[c] = mdl[c][0];
            for (int b = 1; b < NBINS; b++)
                if (mdl[c][b] > exp_pc[c]) begin exp_pb[c] = b; exp_pc[c] = mdl[c][b]; end
        end
        while (beat < NBEATS && cyc < 400) begin
            int ch = beat / NBINS;
            int b = beat % NBINS;
            bit rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            bus.pulse_in = rnd_pulse ? 2'($urandom) : 2'b00;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL out_valid beat=%0d got %b want 1", beat, bus.out_valid); end
            n_checks++; if (int'(bus.out_ch) !== ch) begin n_errors++; $display("FAIL out_ch beat=%0d got %0d want %0d", beat, bus.out_ch, ch); end
            n_checks++; if (int'(bus.out_bin) !== b) begin n_errors++; $display("FAIL out_bin beat=%0d got %0d want %0d", beat, bus.out_bin, b); end
            n_checks++; if (int'(bus.out_count) !== mdl[ch][b]) begin n_errors++; $display("FAIL out_count beat=%0d got %0d want %0d", beat, bus.out_count, mdl[ch][b]); end
            n_checks++; if (bus.out_last !== (beat == NBEATS - 1)) begin n_errors++; $display("FAIL out_last beat=%0d got %b want %b", beat, bus.out_last, beat == NBEATS - 1); end
            if (pk_pend) begin
                n_checks++; if (bus.peak_valid !== 1'b1) begin n_errors++; $display("FAIL peak_valid ch=%0d got %b want 1", pk_ch, bus.peak_valid); end
                n_checks++; if (int'(bus.peak_ch) !== pk_ch) begin n_errors++; $display("FAIL peak_ch got %0d want %0d", bus.peak_ch, pk_ch); end
                n_checks++; if (int'(bus.peak_bin) !== exp_pb[pk_ch]) begin n_errors++; $display("FAIL peak_bin ch=%0d got %0d want %0d", pk_ch, bus.peak_bin, exp_pb[pk_ch]); end
                n_checks++; if (int'(bus.peak_count) !== exp_pc[pk_ch]) begin n_errors++; $display("FAIL peak_count ch=%0d got %0d want %0d", pk_ch, bus.peak_count, exp_pc[pk_ch]); end
            end else begin
                n_checks++; if (bus.peak_valid !== 1'b0) begin n_errors++; $display("FAIL peak_valid_idle beat=%0d got %b want 0", beat, bus.peak_valid); end
            end
            pk_pend = 0;
            tick();
            if (rdy) begin
                if (b == NBINS - 1) begin pk_pend = 1; pk_ch = ch; end
                beat++;
            end
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.pulse_in = 2'b00;
        n_checks++; if (beat !== NBEATS) begin n_errors++; $display("FAIL readout_timeout beats got %0d want %0d", beat, NBEATS); end
        if (!rnd_ready) begin
            n_checks++; if (cyc !== NBEATS) begin n_errors++; $display("FAIL readout_rate cycles got %0d want %0d", cyc, NBEATS); end
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL end_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL end_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.peak_valid !== 1'b1) begin n_errors++; $display("FAIL last_peak_valid got %b want 1", bus.peak_valid); end
        n_checks++; if (int'(bus.peak_ch) !== NUM_CH - 1) begin n_errors++; $display("FAIL last_peak_ch got %0d want %0d", bus.peak_ch, NUM_CH - 1); end
        n_checks++; if (int'(bus.peak_bin) !== exp_pb[NUM_CH-1]) begin n_errors++; $display("FAIL last_peak_bin got %0d want %0d", bus.peak_bin, exp_pb[NUM_CH-1]); end
        n_checks++; if (int'(bus.peak_count) !== exp_pc[NUM_CH-1]) begin n_errors++; $display("FAIL last_peak_count got %0d want %0d", bus.peak_count, exp_pc[NUM_CH-1]); end
        tick();
        n_checks++; if (bus.peak_valid !== 1'b0) begin n_errors++; $display("FAIL peak_strobe_len got %b want 0", bus.peak_valid); end
        clear_model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.busy, bus.err, bus.cur_bin, bus.out_valid, bus.out_ch, bus.out_bin, bus.out_count,
             bus.out_last, bus.peak_valid, bus.peak_ch, bus.peak_bin, bus.peak_count} !== '0) begin
            n_errors++; $display("FAIL reset_outputs busy=%b err=%b valid=%b cnt=%0d peak_valid=%b want all 0",
                                 bus.busy, bus.err, bus.out_valid, bus.out_count, bus.peak_valid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bad_period();
        int bad [2] = '{4, 0};
        for (int i = 0; i < 2; i++) begin
            bus.period = bad[i]; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL bad_period_err period=%0d got %b want 1", bad[i], bus.err); end
            n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL bad_period_busy period=%0d got %b want 0", bad[i], bus.busy); end
        end
        tick();
        n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
    endtask

    task automatic test_binning();
        run_fold(16, 4, 2, 0, 1'b1, -1);
        do_readout(1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        run_fold(64, 2, 5, 1, 1'b0, -1);
        n_checks++; if (mdl[0][3] !== CMAX) begin n_errors++; $display("FAIL sat_model_setup got %0d want %0d", mdl[0][3], CMAX); end
        do_readout(1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_fold(16, 4, 2, 0, 1'b0, -1);
        do_readout(1'b1, 1'b1);
    endtask

    task automatic test_mid_fold_reset();
        run_fold(16, 4, 2, 0, 1'b0, 20);
        test_binning();
    endtask

    task automatic test_back_to_back();
        test_binning();
        test_binning();
    endtask

    task automatic test_simultaneous();
        run_fold(8, 0, 1, 2, 1'b0, -1);
        do_readout(1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_fold($urandom_range(8, 24), $urandom_range(0, 5), $urandom_range(0, 3), 3, 1'b0, -1);
            do_readout(1'b1, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pulse_in = '0; bus.start = 1'b0; bus.period = '0; bus.epoch = '0;
        bus.fold_len = '0; bus.out_ready = 1'b0;
        clear_model();
        test_reset();
        test_bad_period();
        test_binning();
        test_saturation();
        test_backpressure();
        test_mid_fold_reset();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
